// File: rtl/rx_moore.sv
// Serial frame receiver: start bit (1), 8 data bits LSB-first, two stop bits (1).
// Idle line is 0. A good frame updates rx_data with a one-cycle rx_valid strobe;
// a bad stop (or parity) bit raises a one-cycle frame_err strobe and drops the frame.
// Optional even-parity bit after the data: define RX_PARITY_EN.
module rx_moore #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_out
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  // Start is re-checked Half edges after it was first seen.
  localparam logic [CntW-1:0] HalfLast = CntW'((Half > 0) ? Half - 1 : 0);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop1  = 3'd4,
    StStop2  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            bit_tick;

  assign bit_tick = (clk_cnt_q == BitLast);

  // Next-state, sampling and strobe generation.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (rx_in) begin
          state_d = (Half == 0) ? StData : StStart;
        end
      end
      StStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          state_d   = rx_in ? StData : StIdle;  // 0 here means a glitch, no strobe
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_tick) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_in;
          bit_cnt_d          = bit_cnt_q + 3'd1;  // wraps 7->0 on the last bit
          if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop1;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StParity: begin
`ifdef RX_PARITY_EN
        if (bit_tick) begin
          clk_cnt_d = '0;
          if ((^shift_q) ^ rx_in) begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end else begin
            state_d = StStop1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop1: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          if (rx_in) begin
            state_d = StStop2;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop2: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
          if (rx_in) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);
  assign state_out = state_q;

endmodule
